// File: rtl/edge_cap_pkg.sv
// edge_cap_pkg: shared state encoding, packing constants and FIFO entry layout for edge_frame_capture
package edge_cap_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;
  localparam int PIX_PER_WORD = 4;
  localparam int ENTRY_ADDR_W = 32;
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [31:0]             data;
  } entry_t;
endpackage

// File: rtl/edge_frame_capture_sync_fifo.sv
// sync_fifo: entry FIFO whose head (counted in DEPTH) is presented from a register; ports push/din in, ready in, head/head_valid/full/empty out
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, avail;
  logic pop, wr;
  assign pop = head_valid && ready;
  assign wr = push && (!full || pop);
  // entries already stored that survive this cycle's pop; a same-cycle push becomes visible one cycle later
  assign avail = count - (AW+1)'(pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      head <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= avail + (AW+1)'(wr);
      head_valid <= avail != '0;
      if (avail != '0) head <= mem[rd_ptr + AW'(pop)];
    end
  end
endmodule

// File: rtl/edge_frame_capture.sv
// edge_frame_capture: packs 4 edge pixels per word and writes one frame to a word memory port; ports start/pixel in, mem_* handshake out, busy/frame_done/overflow status
module edge_frame_capture
  import edge_cap_pkg::*;
#(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_valid_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] word;
  logic [ADDR_W-1:0] addr;
  logic push_pend, full, empty, take, drop;
  entry_t push_e, head;
  assign take = state == CAPTURE && pixel_valid_in && cnt != CNT_W'(TOTAL);
  assign drop = push_pend && full && !(mem_valid && mem_ready);
  assign push_e = '{addr: ENTRY_ADDR_W'(addr), data: word};
  assign mem_addr = ADDR_W'(head.addr);
  assign mem_wdata = head.data;
  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push_pend), .din(push_e), .ready(mem_ready),
    .head(head), .head_valid(mem_valid), .full(full), .empty(empty)
  );
  // push_pend delays the push one cycle so the fourth byte is already in word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      word <= '0;
      addr <= '0;
      push_pend <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      push_pend <= take && cnt[1:0] == 2'(PIX_PER_WORD - 1);
      if (take) begin
        word[{cnt[1:0], 3'b000} +: 8] <= pixel_in;
        cnt <= cnt + 1'b1;
      end
      if (push_pend) addr <= addr + 1'b1;
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          addr <= '0;
          overflow <= 1'b0;
          busy <= 1'b1;
          state <= CAPTURE;
        end
        CAPTURE: if (cnt == CNT_W'(TOTAL)) state <= DRAIN;
        DRAIN: if (empty && !mem_valid) begin
          busy <= 1'b0;
          frame_done <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_frame_capture.sv
// tb_edge_frame_capture: table-driven and randomized checks of edge_frame_capture against a frame-image model
module tb_edge_frame_capture;
  localparam int W = 8, H = 2, D = 2, AW = 8, NP = W * H, NW = NP / 4;
  typedef struct {
    int ready_mode;
    bit gaps;
    bit early;
    bit restart;
    bit rand_pix;
    int exp_writes;
    int exp_ovf;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, pixel_valid_in = 0, mem_ready = 0;
  logic [7:0] pixel_in = 0;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_valid, busy, frame_done, overflow;
  int errors = 0, checks = 0, cyc = 0, ready_mode = 0, done_cnt = 0, neg_idx = 0, last_hs = 0;
  bit sending = 0, stall_prev = 0, busy_prev = 0;
  logic [AW+31:0] held;
  logic [AW+31:0] got[$];
  logic [7:0] pix[NP];
  vec_t vecs[9];

  always #5 clk = ~clk;

  edge_frame_capture #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? cyc[0] :
                ready_mode == 2 ? !sending : 1'($urandom_range(0, 1));
  endtask

  function automatic logic [31:0] word_of(int a);
    return {pix[4*a+3], pix[4*a+2], pix[4*a+1], pix[4*a]};
  endfunction

  always @(negedge clk) begin
    neg_idx++;
    if (!rst) begin
      if (stall_prev) chk("hold", {mem_valid, mem_addr, mem_wdata}, {1'b1, held});
      if (mem_valid && mem_ready) begin
        got.push_back({mem_addr, mem_wdata});
        last_hs = neg_idx;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_gap", neg_idx - last_hs, 2);
        chk("busy_at_done", {busy_prev, busy}, 2'b10);
      end
    end
    stall_prev = !rst && mem_valid && !mem_ready;
    held = {mem_addr, mem_wdata};
    busy_prev = busy;
  end

  task automatic run_frame(vec_t v, string nm);
    int exp_w, prev, a;
    ready_mode = v.ready_mode;
    sending = 1;
    got.delete();
    done_cnt = 0;
    for (int i = 0; i < NP; i++) pix[i] = v.rand_pix ? 8'($urandom) : 8'(i);
    if (v.early) begin
      for (int i = 0; i < 4; i++) begin
        pixel_valid_in = 1;
        pixel_in = 8'hA0 + 8'(i);
        tick();
      end
      pixel_valid_in = 0;
      repeat (4) tick();
      chk({nm, "_early"}, got.size(), 0);
    end
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < NP; i++) begin
      if (v.gaps) while ($urandom_range(0, 2) == 0) begin
        pixel_valid_in = 0;
        start = 0;
        tick();
      end
      pixel_valid_in = 1;
      pixel_in = pix[i];
      start = v.restart && i == 5;
      tick();
    end
    pixel_valid_in = 0;
    start = 0;
    sending = 0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    chk({nm, "_done"}, done_cnt, 1);
    if (v.exp_ovf >= 0) chk({nm, "_ovf"}, overflow, 64'(v.exp_ovf));
    exp_w = v.exp_writes >= 0 ? v.exp_writes : (overflow ? -1 : NW);
    if (exp_w >= 0) chk({nm, "_nwrites"}, got.size(), 64'(exp_w));
    else chk({nm, "_short"}, got.size() < NW, 1);
    prev = -1;
    foreach (got[i]) begin
      a = int'(got[i][AW+31:32]);
      if (exp_w >= 0) chk({nm, "_addr"}, a, 64'(i));
      else chk({nm, "_asc"}, a > prev, 1);
      prev = a;
      chk({nm, "_range"}, a < NW, 1);
      if (a < NW) chk({nm, "_data"}, got[i][31:0], word_of(a));
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 4, 0};
    vecs[1] = '{1, 1, 0, 0, 0, 4, 0};
    vecs[2] = '{2, 0, 0, 0, 0, 2, 1};
    vecs[3] = '{0, 0, 1, 1, 0, 4, 0};
    vecs[4] = '{1, 1, 0, 0, 1, 4, 0};
    vecs[5] = '{0, 1, 0, 0, 1, 4, 0};
    vecs[6] = '{3, 1, 0, 0, 1, -1, -1};
    vecs[7] = '{3, 0, 0, 0, 1, -1, -1};
    vecs[8] = '{3, 1, 0, 1, 1, -1, -1};
    ready_mode = 3;
    repeat (2) begin
      start = 1;
      pixel_valid_in = 1'($urandom);
      pixel_in = 8'($urandom);
      tick();
    end
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0;
    start = 0;
    pixel_valid_in = 0;
    ready_mode = 0;
    repeat (3) tick();
    chk("rst_no_latch", {busy, mem_valid}, 0);
    for (int v = 0; v < 9; v++) run_frame(vecs[v], $sformatf("vec%0d", v));
    ready_mode = 0;
    sending = 0;
    got.delete();
    done_cnt = 0;
    chk("lat_busy_pre", busy, 0);
    start = 1;
    tick();
    start = 0;
    chk("lat_busy_post", busy, 1);
    for (int i = 0; i < NP; i++) begin
      pixel_valid_in = 1;
      pixel_in = 8'(i);
      tick();
      if (i == 3) chk("lat_k", mem_valid, 0);
      if (i == 4) chk("lat_k1", mem_valid, 0);
      if (i == 5) chk("lat_k2", {mem_valid, mem_addr, mem_wdata}, {1'b1, 8'h00, 32'h03020100});
    end
    pixel_valid_in = 0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    chk("lat_done", done_cnt, 1);
    chk("lat_nwrites", got.size(), NW);
    ready_mode = 2;
    sending = 1;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 6; i++) begin
      pixel_valid_in = 1;
      pixel_in = 8'h40 + 8'(i);
      tick();
    end
    pixel_valid_in = 0;
    chk("pre_rst_valid", mem_valid, 1);
    rst = 1;
    tick();
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 0;
    tick();
    run_frame(vecs[0], "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
